// File: rtl/controle_rodadas_pkg.sv
// Shared definitions for the round-control FSM: state-register width and the
// state codes shown on the hex debug display.
package controle_rodadas_pkg;

    localparam int ESTADO_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        ST_INICIAL        = 4'h0,
        ST_PREPARACAO     = 4'h1,
        ST_INICIO_RODADA  = 4'h2,
        ST_ESPERA         = 4'h3,
        ST_REGISTRA       = 4'h4,
        ST_COMPARACAO     = 4'h5,
        ST_PROXIMO        = 4'h6,
        ST_PROXIMA_RODADA = 4'h7,
        ST_FIM_ACERTO     = 4'hA,
        ST_FIM_TIMEOUT    = 4'hD,
        ST_FIM_ERRO       = 4'hE
    } estado_t;

    function automatic logic is_terminal(input estado_t s);
        return (s == ST_FIM_ACERTO) || (s == ST_FIM_ERRO) || (s == ST_FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/controle_rodadas.sv
// Moore control unit for the round-based memory game.
// Build option: define TIMEOUT_EN to let the move timer end the game.
module controle_rodadas
    import controle_rodadas_pkg::*;
#(
    parameter int ESTADO_W = controle_rodadas_pkg::ESTADO_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada,
    input  logic                igual,
    input  logic                fimE,
    input  logic                fimL,
    input  logic                fim_timer,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraL,
    output logic                contaL,
    output logic                zeraR,
    output logic                registraR,
    output logic                zeraT,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                db_timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t estado_q, estado_d;
    logic    timer_unused;

`ifdef TIMEOUT_EN
    assign timer_unused = 1'b0;
`else
    assign timer_unused = fim_timer;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = ST_INICIAL;
        case (estado_q)
            ST_INICIAL:        estado_d = iniciar ? ST_PREPARACAO : ST_INICIAL;
            ST_PREPARACAO:     estado_d = ST_INICIO_RODADA;
            ST_INICIO_RODADA:  estado_d = ST_ESPERA;
            ST_ESPERA: begin
                // jogada has priority over a simultaneous timer expiry
                if (jogada) begin
                    estado_d = ST_REGISTRA;
`ifdef TIMEOUT_EN
                end else if (fim_timer) begin
                    estado_d = ST_FIM_TIMEOUT;
`endif
                end else begin
                    estado_d = ST_ESPERA;
                end
            end
            ST_REGISTRA:       estado_d = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!igual)     estado_d = ST_FIM_ERRO;
                else if (!fimE) estado_d = ST_PROXIMO;
                else if (!fimL) estado_d = ST_PROXIMA_RODADA;
                else            estado_d = ST_FIM_ACERTO;
            end
            ST_PROXIMO:        estado_d = ST_ESPERA;
            ST_PROXIMA_RODADA: estado_d = ST_INICIO_RODADA;
            ST_FIM_ACERTO,
`ifdef TIMEOUT_EN
            ST_FIM_TIMEOUT,
`endif
            ST_FIM_ERRO:       estado_d = iniciar ? ST_PREPARACAO : estado_q;
            default:           estado_d = ST_INICIAL;
        endcase
    end

    always_comb begin
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraL      = 1'b0;
        contaL     = 1'b0;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        zeraT      = 1'b0;
        pronto     = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        db_timeout = 1'b0;
        case (estado_q)
            ST_PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                zeraT = 1'b1;
            end
            ST_INICIO_RODADA: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            ST_REGISTRA:       registraR = 1'b1;
            ST_PROXIMO: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            ST_PROXIMA_RODADA: contaL = 1'b1;
            ST_FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            ST_FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            ST_FIM_TIMEOUT: begin
                pronto     = 1'b1;
                errou      = 1'b1;
                db_timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = ESTADO_W'(estado_q);

endmodule

// File: tb/tb_controle_rodadas.sv
// Scoreboard bench for controle_rodadas; honours TIMEOUT_EN like the design.
module tb_controle_rodadas;
    import controle_rodadas_pkg::*;

    logic clock = 1'b0;
    logic reset, iniciar, jogada, igual, fimE, fimL, fim_timer;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT;
    logic pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;

    controle_rodadas #(.ESTADO_W(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimL(fimL), .fim_timer(fim_timer),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT),
        .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  estado;
        logic [10:0] outs;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   step_no = 0;
    int   e_mdl = 0;
    int   l_mdl = 0;
    bit   model_en = 0;
    int   contaE_seen = 0;
    int   contaL_seen = 0;

    // Bit order: zeraE contaE zeraL contaL zeraR registraR zeraT pronto acertou errou db_timeout
    function automatic logic [10:0] outs_for(input logic [3:0] s);
        case (s)
            4'h1: return 11'b10101010000;
            4'h2: return 11'b10000010000;
            4'h4: return 11'b00000100000;
            4'h6: return 11'b01000010000;
            4'h7: return 11'b00010000000;
            4'hA: return 11'b00000001100;
            4'hE: return 11'b00000001010;
`ifdef TIMEOUT_EN
            4'hD: return 11'b00000001011;
`endif
            default: return 11'b00000000000;
        endcase
    endfunction

    // One clock edge; the state expected after that edge is queued for the monitor.
    task automatic tick(input logic [3:0] s);
        exp_t x;
        logic [10:0] o;
        @(posedge clock);
        step_no++;
        o = outs_for(s);
        x.estado = s;
        x.outs = o;
        x.step = step_no;
        exp_q.push_back(x);
        if (o[10]) e_mdl = 0;
        if (o[9])  begin e_mdl++; contaE_seen++; end
        if (o[8])  l_mdl = 0;
        if (o[7])  begin l_mdl++; contaL_seen++; end
        #2;
        if (model_en) begin
            fimE = (e_mdl == l_mdl);
            fimL = (l_mdl == 1);
        end
    endtask

    initial begin : monitor
        exp_t x;
        logic [10:0] act;
        forever begin
            @(posedge clock);
            #1;
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                act = {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT,
                       pronto, acertou, errou, db_timeout};
                checks++;
                if (db_estado === x.estado) passed++;
                else $display("FAIL estado step %0d: got %h expected %h", x.step, db_estado, x.estado);
                checks++;
                if (act === x.outs) passed++;
                else $display("FAIL outputs step %0d (state %h): got %b expected %b",
                              x.step, x.estado, act, x.outs);
            end
        end
    end

    initial begin : stimulus
        reset = 1; iniciar = 0; jogada = 0; igual = 0;
        fimE = 0; fimL = 0; fim_timer = 0;
        #2;
        tick(4'h0);
        tick(4'h0);
        reset = 0;
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2);
        tick(4'h3);
        tick(4'h3);

        // reset mid-espera for two cycles
        reset = 1; tick(4'h0);
        tick(4'h0);
        reset = 0;
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2);
        tick(4'h3);

        // wrong first move
        jogada = 1; igual = 0; tick(4'h4);
        jogada = 0; tick(4'h5);
        tick(4'hE);
        tick(4'hE);
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2);
        tick(4'h3);

        // jogada together with fim_timer: the move wins
        jogada = 1; fim_timer = 1; tick(4'h4);
        jogada = 0; fim_timer = 0; igual = 1; fimE = 0; tick(4'h5);
        tick(4'h6);
        tick(4'h3);

        // iniciar held through espera/registra/comparacao has no effect
        iniciar = 1; tick(4'h3);
        jogada = 1; igual = 0; tick(4'h4);
        jogada = 0; tick(4'h5);
        tick(4'hE);
        tick(4'h1);
        iniciar = 0; tick(4'h2);
        tick(4'h3);

        // two-round win with modelled E/L counters
        model_en = 1; igual = 1;
        fimE = (e_mdl == l_mdl); fimL = (l_mdl == 1);
        contaE_seen = 0; contaL_seen = 0;
        jogada = 1; tick(4'h4);
        jogada = 0; tick(4'h5);
        tick(4'h7);
        tick(4'h2);
        tick(4'h3);
        jogada = 1; tick(4'h4);
        jogada = 0; tick(4'h5);
        tick(4'h6);
        tick(4'h3);
        jogada = 1; tick(4'h4);
        jogada = 0; tick(4'h5);
        tick(4'hA);
        tick(4'hA);
        model_en = 0;
        checks++;
        if (contaE_seen == 1 && contaL_seen == 1 && e_mdl == 1 && l_mdl == 1) passed++;
        else $display("FAIL win_counts: contaE %0d contaL %0d required 1 1", contaE_seen, contaL_seen);

        // timer expiry while waiting for a move
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2);
        tick(4'h3);
        fim_timer = 1;
`ifdef TIMEOUT_EN
        tick(4'hD);
        fim_timer = 0; tick(4'hD);
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2);
        tick(4'h3);
`else
        for (int i = 0; i < 100; i++) tick(4'h3);
        fim_timer = 0;
`endif

        // unused code falls back to inicial
        force dut.estado_q = estado_t'(4'h9);
        #1;
        release dut.estado_q;
        tick(4'h0);
        tick(4'h0);

        @(posedge clock);
        #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
